// File: rtl/retire_scoreboard.sv
// rtl/retire_scoreboard.sv - in-order retirement checker with expected-record queue
// Pops one expected record per retire, latches the first mismatch, counts retirements and flags clean HLT.
module retire_scoreboard #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int REG_W  = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_exp_valid,
   output logic                      o_exp_ready,
   input  logic [ADDR_W-1:0]         i_exp_pc,
   input  logic [REG_W-1:0]          i_exp_rd,
   input  logic [DATA_W-1:0]         i_exp_data,
   input  logic                      i_exp_we,
   input  logic                      i_exp_hlt,
   input  logic                      i_ret_valid,
   input  logic [ADDR_W-1:0]         i_ret_pc,
   input  logic [REG_W-1:0]          i_ret_rd,
   input  logic [DATA_W-1:0]         i_ret_data,
   input  logic                      i_ret_we,
   input  logic                      i_ret_hlt,
   input  logic                      i_err_clr,
   output logic                      o_error,
   output logic [2:0]                o_err_code,
   output logic [ADDR_W-1:0]         o_err_pc,
   output logic [DATA_W-1:0]         o_err_exp,
   output logic [DATA_W-1:0]         o_err_act,
   output logic [CNT_W-1:0]          o_retired_cnt,
   output logic [$clog2(DEPTH):0]    o_occupancy,
   output logic                      o_done
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
   logic [REG_W-1:0]  r_rd_mem   [DEPTH];
   logic [DATA_W-1:0] r_data_mem [DEPTH];
   logic              r_we_mem   [DEPTH];
   logic              r_hlt_mem  [DEPTH];

   logic [OW-1:0]     r_wr_ptr;
   logic [OW-1:0]     r_rd_ptr;
   logic              r_error;
   logic [2:0]        r_err_code;
   logic [ADDR_W-1:0] r_err_pc;
   logic [DATA_W-1:0] r_err_exp;
   logic [DATA_W-1:0] r_err_act;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_done;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_h_pc;
   logic [REG_W-1:0]  w_h_rd;
   logic [DATA_W-1:0] w_h_data;
   logic              w_h_we;
   logic              w_h_hlt;
   logic [2:0]        w_code;
   logic [DATA_W-1:0] w_exp_data;

   // The extra wrap bit distinguishes full from empty when the index bits match.
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_exp_ready = !w_full && !r_done;
   assign w_push      = i_exp_valid && o_exp_ready;
   assign w_pop       = i_ret_valid && !w_empty && !r_done;

   assign w_h_pc   = r_pc_mem[r_rd_ptr[AW-1:0]];
   assign w_h_rd   = r_rd_mem[r_rd_ptr[AW-1:0]];
   assign w_h_data = r_data_mem[r_rd_ptr[AW-1:0]];
   assign w_h_we   = r_we_mem[r_rd_ptr[AW-1:0]];
   assign w_h_hlt  = r_hlt_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr[AW-1:0]]   <= i_exp_pc;
         r_rd_mem[r_wr_ptr[AW-1:0]]   <= i_exp_rd;
         r_data_mem[r_wr_ptr[AW-1:0]] <= i_exp_data;
         r_we_mem[r_wr_ptr[AW-1:0]]   <= i_exp_we;
         r_hlt_mem[r_wr_ptr[AW-1:0]]  <= i_exp_hlt;
      end
   end

   // Once done, no record is popped, so retire-after-done outranks the empty-queue check.
   always_comb begin
      w_code     = 3'd0;
      w_exp_data = '0;
      if (i_ret_valid) begin
         if (r_done) begin
            w_code = 3'd7;
         end else if (w_empty) begin
            w_code = 3'd1;
         end else begin
            w_exp_data = w_h_data;
            if (i_ret_pc != w_h_pc)
               w_code = 3'd2;
            else if (i_ret_we != w_h_we)
               w_code = 3'd3;
            else if (w_h_we && (i_ret_rd != w_h_rd))
               w_code = 3'd4;
            else if (w_h_we && (w_h_rd != '0) && (i_ret_data != w_h_data))
               w_code = 3'd5;
            else if (i_ret_hlt != w_h_hlt)
               w_code = 3'd6;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_error    <= 1'b0;
         r_err_code <= 3'd0;
         r_err_pc   <= '0;
         r_err_exp  <= '0;
         r_err_act  <= '0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + OW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + OW'(1);
         if (w_pop && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_pop && w_h_hlt && i_ret_hlt && (w_code == 3'd0))
            r_done <= 1'b1;
         // A fresh error in the clearing cycle wins over the clear.
         if ((w_code != 3'd0) && (!r_error || i_err_clr)) begin
            r_error    <= 1'b1;
            r_err_code <= w_code;
            r_err_pc   <= i_ret_pc;
            r_err_exp  <= w_exp_data;
            r_err_act  <= i_ret_data;
         end else if (i_err_clr) begin
            r_error    <= 1'b0;
            r_err_code <= 3'd0;
            r_err_pc   <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
         end
      end
   end

   assign o_error       = r_error;
   assign o_err_code    = r_err_code;
   assign o_err_pc      = r_err_pc;
   assign o_err_exp     = r_err_exp;
   assign o_err_act     = r_err_act;
   assign o_retired_cnt = r_cnt;
   assign o_occupancy   = r_wr_ptr - r_rd_ptr;
   assign o_done        = r_done;

endmodule
